// File: rtl/piezo_sound_sequencer.sv
// Game audio back-end: arbitrates game events into one square-wave piezo drive,
// playing single tones or short constant melodies split into fixed-length note slots.
module piezo_sound_sequencer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NOTE_MS  = 125,
  parameter int CLICK_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_click,
  input  logic       phase_clear,
  input  logic       warn_in,
  input  logic       game_clear,
  input  logic       game_over,
  output logic       piezo_out,
  output logic       busy,
  output logic       melody_done,
  output logic [2:0] dbg_state
);

  localparam int          NOTE_CYC   = (CLK_HZ / 1000) * NOTE_MS;
  localparam int          CLICK_CYC  = (CLK_HZ / 1000) * CLICK_MS;
  localparam logic [31:0] NOTE_LAST  = 32'(NOTE_CYC - 1);
  localparam logic [31:0] CLICK_LAST = 32'(CLICK_CYC - 1);

  localparam logic [23:0] H_CLICK = 24'(CLK_HZ / (2 * 4000));
  localparam logic [23:0] H_WARN  = 24'(CLK_HZ / (2 * 2000));
  localparam logic [23:0] H_A3    = 24'(CLK_HZ / (2 * 220));
  localparam logic [23:0] H_A4    = 24'(CLK_HZ / (2 * 440));
  localparam logic [23:0] H_C5    = 24'(CLK_HZ / (2 * 523));
  localparam logic [23:0] H_E5    = 24'(CLK_HZ / (2 * 659));
  localparam logic [23:0] H_G5    = 24'(CLK_HZ / (2 * 784));
  localparam logic [23:0] H_C6    = 24'(CLK_HZ / (2 * 1047));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLICK   = 3'd1,
    S_JINGLE  = 3'd2,
    S_WARN    = 3'd3,
    S_FANFARE = 3'd4,
    S_DIRGE   = 3'd5,
    S_HOLD    = 3'd6
  } state_t;

  state_t      r_state;
  logic [2:0]  r_slot;
  logic [31:0] r_dur;
  logic [23:0] r_div;
  logic        r_piezo;
  logic        r_busy;
  logic        r_done;
  logic        r_clear_d;
  logic        r_over_d;
  logic        r_hold_over;

  logic        w_over_rise;
  logic        w_clear_rise;
  state_t      w_req_state;
  logic [2:0]  w_req_pri;
  logic [2:0]  w_cur_pri;
  logic        w_take;
  logic [23:0] w_half;
  logic [2:0]  w_last_slot;
  logic [23:0] w_div_next;
  logic        w_piezo_next;

  assign w_over_rise  = game_over & ~r_over_d;
  assign w_clear_rise = game_clear & ~r_clear_d;

  always_comb begin
    w_req_state = S_IDLE;
    w_req_pri   = 3'd0;
    if (w_over_rise) begin
      w_req_state = S_DIRGE;   w_req_pri = 3'd5;
    end else if (w_clear_rise) begin
      w_req_state = S_FANFARE; w_req_pri = 3'd4;
    end else if (warn_in) begin
      w_req_state = S_WARN;    w_req_pri = 3'd3;
    end else if (phase_clear) begin
      w_req_state = S_JINGLE;  w_req_pri = 3'd2;
    end else if (key_click) begin
      w_req_state = S_CLICK;   w_req_pri = 3'd1;
    end
  end

  // HOLD keeps the rank of the melody that led into it.
  always_comb begin
    w_cur_pri = 3'd0;
    case (r_state)
      S_CLICK:   w_cur_pri = 3'd1;
      S_JINGLE:  w_cur_pri = 3'd2;
      S_WARN:    w_cur_pri = 3'd3;
      S_FANFARE: w_cur_pri = 3'd4;
      S_DIRGE:   w_cur_pri = 3'd5;
      S_HOLD:    w_cur_pri = r_hold_over ? 3'd5 : 3'd4;
      default:   w_cur_pri = 3'd0;
    endcase
  end

  // A held warning must not restart its own tone every cycle.
  assign w_take = (w_req_pri != 3'd0) &&
                  ((w_req_pri > w_cur_pri) ||
                   ((w_req_pri == w_cur_pri) && (w_req_state != S_WARN)));

  always_comb begin
    w_half      = 24'd0;
    w_last_slot = 3'd0;
    case (r_state)
      S_CLICK: w_half = H_CLICK;
      S_WARN:  w_half = H_WARN;
      S_JINGLE: begin
        w_last_slot = 3'd1;
        w_half      = (r_slot == 3'd0) ? H_E5 : H_G5;
      end
      S_FANFARE: begin
        w_last_slot = 3'd4;
        case (r_slot)
          3'd0:    w_half = H_C5;
          3'd1:    w_half = H_E5;
          3'd2:    w_half = H_G5;
          default: w_half = H_C6;
        endcase
      end
      S_DIRGE: begin
        w_last_slot = 3'd3;
        case (r_slot)
          3'd0:    w_half = H_A4;
          3'd1:    w_half = 24'd0;
          default: w_half = H_A3;
        endcase
      end
      default: w_half = 24'd0;
    endcase
  end

  // A zero half-period means rest: output pinned low.
  always_comb begin
    w_div_next   = 24'd0;
    w_piezo_next = 1'b0;
    if (w_half != 24'd0) begin
      if (r_div == w_half - 24'd1) begin
        w_piezo_next = ~r_piezo;
      end else begin
        w_div_next   = r_div + 24'd1;
        w_piezo_next = r_piezo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_slot      <= 3'd0;
      r_dur       <= 32'd0;
      r_div       <= 24'd0;
      r_piezo     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear_d   <= 1'b0;
      r_over_d    <= 1'b0;
      r_hold_over <= 1'b0;
    end else begin
      r_clear_d <= game_clear;
      r_over_d  <= game_over;
      r_done    <= 1'b0;
      r_div     <= w_div_next;
      r_piezo   <= w_piezo_next;
      r_dur     <= r_dur + 32'd1;
      if (w_take) begin
        r_state <= w_req_state;
        r_slot  <= 3'd0;
        r_dur   <= 32'd0;
        r_div   <= 24'd0;
        r_piezo <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: r_dur <= 32'd0;
          S_CLICK: begin
            if (r_dur == CLICK_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_dur   <= 32'd0;
              r_div   <= 24'd0;
              r_piezo <= 1'b0;
            end
          end
          S_WARN: begin
            r_dur <= 32'd0;
            if (!warn_in) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_div   <= 24'd0;
              r_piezo <= 1'b0;
            end
          end
          S_JINGLE, S_FANFARE, S_DIRGE: begin
            if (r_dur == NOTE_LAST) begin
              r_dur   <= 32'd0;
              r_div   <= 24'd0;
              r_piezo <= 1'b0;
              if (r_slot == w_last_slot) begin
                r_slot <= 3'd0;
                r_busy <= 1'b0;
                if (r_state == S_JINGLE) begin
                  r_state <= S_IDLE;
                end else begin
                  r_state     <= S_HOLD;
                  r_done      <= 1'b1;
                  r_hold_over <= (r_state == S_DIRGE);
                end
              end else begin
                r_slot <= r_slot + 3'd1;
              end
            end
          end
          S_HOLD: begin
            r_dur <= 32'd0;
            if (r_hold_over ? !game_over : !game_clear) r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign piezo_out   = r_piezo;
  assign busy        = r_busy;
  assign melody_done = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_piezo_sound_sequencer.sv
// Bench for piezo_sound_sequencer: table of timed probes, hand-written corner sequences
// and random events, all shadowed every cycle by an arithmetic reference model.
module tb_piezo_sound_sequencer;

  localparam int CLK_HZ    = 1_000_000;
  localparam int NOTE_MS   = 4;
  localparam int CLICK_MS  = 2;
  localparam int NOTE_CYC  = (CLK_HZ / 1000) * NOTE_MS;
  localparam int CLICK_CYC = (CLK_HZ / 1000) * CLICK_MS;

  // Sound kinds, numbered by priority; HOLD ranks as its originating melody.
  localparam int K_IDLE = 0, K_CLICK = 1, K_JINGLE = 2, K_WARN = 3;
  localparam int K_FANFARE = 4, K_DIRGE = 5, K_HOLD = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_click = 1'b0, phase_clear = 1'b0, warn_in = 1'b0;
  logic       game_clear = 1'b0, game_over = 1'b0;
  logic       piezo_out, busy, melody_done;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int model_fails = 0;

  always #5 clk = ~clk;

  piezo_sound_sequencer #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS), .CLICK_MS(CLICK_MS)) dut (
    .clk(clk), .rst_n(rst_n), .key_click(key_click), .phase_clear(phase_clear),
    .warn_in(warn_in), .game_clear(game_clear), .game_over(game_over),
    .piezo_out(piezo_out), .busy(busy), .melody_done(melody_done), .dbg_state(dbg_state)
  );

  typedef struct {
    int kind;
    int age;
    bit hold_over;
    bit done;
    bit pc;
    bit po;
  } model_t;

  typedef struct {
    int stim;
    int j;
    bit ep;
    bit eb;
    bit ed;
  } vec_t;

  model_t m;
  vec_t   vq[$];

  function automatic int n_slots(int kind);
    case (kind)
      K_JINGLE:  return 2;
      K_FANFARE: return 5;
      K_DIRGE:   return 4;
      default:   return 0;
    endcase
  endfunction

  function automatic int note_freq(int kind, int slot);
    int jf[2] = '{659, 784};
    int ff[5] = '{523, 659, 784, 1047, 1047};
    int df[4] = '{440, 0, 220, 220};
    if (slot < 0 || slot >= n_slots(kind)) return 0;
    case (kind)
      K_JINGLE:  return jf[slot];
      K_FANFARE: return ff[slot];
      K_DIRGE:   return df[slot];
      default:   return 0;
    endcase
  endfunction

  function automatic bit square(int t, int freq);
    int h;
    if (freq == 0) return 1'b0;
    h = CLK_HZ / (2 * freq);
    return ((t / h) % 2) != 0;
  endfunction

  function automatic bit exp_piezo(model_t s);
    case (s.kind)
      K_CLICK:  return square(s.age, 4000);
      K_WARN:   return square(s.age, 2000);
      K_JINGLE, K_FANFARE, K_DIRGE:
        return square(s.age % NOTE_CYC, note_freq(s.kind, s.age / NOTE_CYC));
      default:  return 1'b0;
    endcase
  endfunction

  function automatic bit exp_busy(model_t s);
    return (s.kind >= K_CLICK) && (s.kind <= K_DIRGE);
  endfunction

  function automatic model_t model_reset();
    model_t z;
    z.kind = K_IDLE; z.age = 0; z.hold_over = 1'b0;
    z.done = 1'b0; z.pc = 1'b0; z.po = 1'b0;
    return z;
  endfunction

  function automatic model_t model_next(model_t s, bit key, bit ph, bit wn, bit clr, bit ovr);
    model_t n;
    int rk;
    int cp;
    n = s;
    n.done = 1'b0;
    if (ovr && !s.po)      rk = K_DIRGE;
    else if (clr && !s.pc) rk = K_FANFARE;
    else if (wn)           rk = K_WARN;
    else if (ph)           rk = K_JINGLE;
    else if (key)          rk = K_CLICK;
    else                   rk = K_IDLE;
    cp = (s.kind == K_HOLD) ? (s.hold_over ? K_DIRGE : K_FANFARE) : s.kind;
    if (rk != K_IDLE && (rk > cp || (rk == cp && rk != K_WARN))) begin
      n.kind = rk;
      n.age  = 0;
    end else begin
      case (s.kind)
        K_CLICK: begin
          if (s.age == CLICK_CYC - 1) begin n.kind = K_IDLE; n.age = 0; end
          else n.age = s.age + 1;
        end
        K_WARN: begin
          if (!wn) begin n.kind = K_IDLE; n.age = 0; end
          else n.age = s.age + 1;
        end
        K_JINGLE, K_FANFARE, K_DIRGE: begin
          if (s.age == n_slots(s.kind) * NOTE_CYC - 1) begin
            n.age = 0;
            if (s.kind == K_JINGLE) begin
              n.kind = K_IDLE;
            end else begin
              n.kind = K_HOLD;
              n.done = 1'b1;
              n.hold_over = (s.kind == K_DIRGE);
            end
          end else begin
            n.age = s.age + 1;
          end
        end
        K_HOLD: if (s.hold_over ? !ovr : !clr) n.kind = K_IDLE;
        default: n.age = 0;
      endcase
    end
    n.pc = clr;
    n.po = ovr;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the inputs as they stand, then sample at the falling edge.
  task automatic tick();
    int f0;
    if (!rst_n) m = model_reset();
    else m = model_next(m, key_click, phase_clear, warn_in, game_clear, game_over);
    @(posedge clk);
    @(negedge clk);
    if (model_fails < 20) begin
      f0 = failures;
      check("model_piezo", {31'd0, piezo_out}, {31'd0, exp_piezo(m)});
      check("model_busy", {31'd0, busy}, {31'd0, exp_busy(m)});
      check("model_done", {31'd0, melody_done}, {31'd0, m.done});
      if (failures != f0) model_fails++;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_click = 1'b0; phase_clear = 1'b0; warn_in = 1'b0;
    game_clear = 1'b0; game_over = 1'b0;
    m = model_reset();
    ticks(3);
    rst_n = 1'b1;
  endtask

  task automatic start_stim(input int stim);
    do_reset();
    case (stim)
      1: key_click = 1'b1;
      2: phase_clear = 1'b1;
      3: warn_in = 1'b1;
      default: game_clear = 1'b1;
    endcase
    tick();
    key_click = 1'b0;
    phase_clear = 1'b0;
  endtask

  task automatic add_vec(input int stim, input int j, input bit ep, input bit eb, input bit ed);
    vec_t v;
    v.stim = stim; v.j = j; v.ep = ep; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endtask

  initial begin
    int cur_stim;
    int cur_j;

    // j = clock edges counted from the edge that samples the request.
    add_vec(1, 1, 1'b0, 1'b1, 1'b0);     add_vec(1, 125, 1'b0, 1'b1, 1'b0);
    add_vec(1, 126, 1'b1, 1'b1, 1'b0);   add_vec(1, 251, 1'b0, 1'b1, 1'b0);
    add_vec(1, 2000, 1'b1, 1'b1, 1'b0);  add_vec(1, 2001, 1'b0, 1'b0, 1'b0);
    add_vec(2, 1, 1'b0, 1'b1, 1'b0);     add_vec(2, 759, 1'b1, 1'b1, 1'b0);
    add_vec(2, 4001, 1'b0, 1'b1, 1'b0);  add_vec(2, 4638, 1'b1, 1'b1, 1'b0);
    add_vec(2, 8000, 1'b0, 1'b1, 1'b0);  add_vec(2, 8001, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1, 1'b0, 1'b1, 1'b0);     add_vec(3, 250, 1'b0, 1'b1, 1'b0);
    add_vec(3, 251, 1'b1, 1'b1, 1'b0);
    add_vec(4, 956, 1'b0, 1'b1, 1'b0);   add_vec(4, 957, 1'b1, 1'b1, 1'b0);
    add_vec(4, 4001, 1'b0, 1'b1, 1'b0);  add_vec(4, 20000, 1'b0, 1'b1, 1'b0);
    add_vec(4, 20001, 1'b0, 1'b0, 1'b1); add_vec(4, 20002, 1'b0, 1'b0, 1'b0);

    // Power-on reset
    m = model_reset();
    ticks(3);
    check("reset_piezo", {31'd0, piezo_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, melody_done}, 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Timed probe table
    cur_stim = -1;
    cur_j = 0;
    foreach (vq[i]) begin
      if (vq[i].stim != cur_stim || vq[i].j <= cur_j) begin
        start_stim(vq[i].stim);
        cur_stim = vq[i].stim;
        cur_j = 1;
      end
      ticks(vq[i].j - cur_j);
      cur_j = vq[i].j;
      check($sformatf("vec%0d_piezo", i), {31'd0, piezo_out}, {31'd0, vq[i].ep});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].eb});
      check($sformatf("vec%0d_done", i), {31'd0, melody_done}, {31'd0, vq[i].ed});
    end

    // Still in HOLD after the fanfare: clicks are dropped until game_clear falls
    key_click = 1'b1; tick(); key_click = 1'b0;
    check("hold_drops_click", {31'd0, busy}, 32'd0);
    game_clear = 1'b0; tick();
    key_click = 1'b1; tick(); key_click = 1'b0;
    check("idle_after_hold", {31'd0, busy}, 32'd1);

    // Click during jingle is dropped
    start_stim(2);
    ticks(99);
    key_click = 1'b1; tick(); key_click = 1'b0;
    ticks(1500);
    check("jingle_keeps_piezo", {31'd0, piezo_out}, 32'd0);
    ticks(600);
    check("jingle_keeps_busy", {31'd0, busy}, 32'd1);

    // Simultaneous click and phase clear
    do_reset();
    key_click = 1'b1; phase_clear = 1'b1; tick();
    key_click = 1'b0; phase_clear = 1'b0;
    ticks(125);
    check("simul_jingle_piezo", {31'd0, piezo_out}, 32'd0);
    ticks(2000);
    check("simul_jingle_busy", {31'd0, busy}, 32'd1);

    // Warning preempts jingle; jingle does not resume
    start_stim(2);
    ticks(1000);
    check("jingle_pre_warn", {31'd0, piezo_out}, 32'd1);
    warn_in = 1'b1; tick();
    check("warn_entry_piezo", {31'd0, piezo_out}, 32'd0);
    check("warn_entry_busy", {31'd0, busy}, 32'd1);
    ticks(250);
    check("warn_rise", {31'd0, piezo_out}, 32'd1);
    ticks(250);
    check("warn_fall", {31'd0, piezo_out}, 32'd0);
    warn_in = 1'b0; tick();
    check("warn_exit_busy", {31'd0, busy}, 32'd0);
    ticks(100);
    check("jingle_not_resumed", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of the fanfare
    start_stim(4);
    ticks(1000);
    check("pre_reset_piezo", {31'd0, piezo_out}, 32'd1);
    rst_n = 1'b0;
    game_clear = 1'b0;
    #1;
    check("async_reset_piezo", {31'd0, piezo_out}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    m = model_reset();
    ticks(2);
    rst_n = 1'b1;
    ticks(50);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    // game_over during fanfare slot 2 switches to the dirge
    start_stim(4);
    ticks(8100);
    game_over = 1'b1; tick();
    check("dirge_entry_busy", {31'd0, busy}, 32'd1);
    check("dirge_entry_piezo", {31'd0, piezo_out}, 32'd0);
    ticks(1135);
    check("dirge_a4_low", {31'd0, piezo_out}, 32'd0);
    tick();
    check("dirge_a4_rise", {31'd0, piezo_out}, 32'd1);
    ticks(1136);
    check("dirge_a4_period", {31'd0, piezo_out}, 32'd0);
    ticks(3728);
    check("dirge_rest_piezo", {31'd0, piezo_out}, 32'd0);
    check("dirge_rest_busy", {31'd0, busy}, 32'd1);
    ticks(4272);
    check("dirge_a3_rise", {31'd0, piezo_out}, 32'd1);
    ticks(5727);
    check("dirge_last_busy", {31'd0, busy}, 32'd1);
    tick();
    check("dirge_done", {31'd0, melody_done}, 32'd1);
    check("dirge_hold_busy", {31'd0, busy}, 32'd0);
    tick();
    check("dirge_done_once", {31'd0, melody_done}, 32'd0);
    game_over = 1'b0; tick();
    game_clear = 1'b0; tick();
    key_click = 1'b1; tick(); key_click = 1'b0;
    check("idle_after_dirge", {31'd0, busy}, 32'd1);

    // Random events against the model
    do_reset();
    for (int c = 0; c < 15000; c++) begin
      key_click   = ($urandom_range(0, 199) == 0);
      phase_clear = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 2499) == 0) warn_in = ~warn_in;
      if ($urandom_range(0, 5999) == 0) game_clear = ~game_clear;
      if ($urandom_range(0, 8999) == 0) game_over = ~game_over;
      tick();
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
